// File: rtl/mem_write_checker.sv
// Store-bus self-check: compares snooped data-memory writes against a programmable
// table of expected (address, data) pairs and reports sticky pass/fail with diagnostics.
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT = 1024,
  parameter int ORDERED = 1,
  localparam int IDX_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int CNT_W  = $clog2(NUM_EXP + 1),
  localparam int TMR_W  = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             ign_en,
  input  logic [WIDTH-1:0] ign_addr,
  input  logic [CNT_W-1:0] exp_num,
  input  logic             start,
  input  logic             clr,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   tab_addr_q [NUM_EXP];
  logic [WIDTH-1:0]   tab_data_q [NUM_EXP];
  logic [NUM_EXP-1:0] pend_q;
  logic [CNT_W-1:0]   exp_q, match_cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic               busy_q, done_q, pass_q, fail_q;
  logic [1:0]         fail_code_q;
  logic [WIDTH-1:0]   fail_addr_q, fail_data_q;

  logic               hit, addr_hit, mism, fin, tmo, exp_bad;
  logic [IDX_W-1:0]   hit_idx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [TMR_W-1:0]   timer_inc;
  logic [NUM_EXP-1:0] pend_init;

  // addr_hit marks a store aimed at a candidate entry; such a store is never
  // excused by the ignored address even when its data is wrong.
  always_comb begin
    hit      = 1'b0;
    addr_hit = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (ORDERED != 0) begin
        if (CNT_W'(i) == match_cnt_q) begin
          addr_hit = (tab_addr_q[i] == dataadr);
          hit      = addr_hit && (tab_data_q[i] == writedata);
          hit_idx  = IDX_W'(i);
        end
      end else if (pend_q[i] && tab_addr_q[i] == dataadr) begin
        addr_hit = 1'b1;
        if (!hit && tab_data_q[i] == writedata) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EXP; i++) pend_init[i] = (i < int'(exp_num));
  end

  assign cnt_inc   = match_cnt_q + CNT_W'(1);
  assign timer_inc = timer_q + TMR_W'(1);
  assign fin       = memwrite && hit && (cnt_inc == exp_q);
  assign mism      = memwrite && !hit && !(ign_en && dataadr == ign_addr && !addr_hit);
  assign tmo       = (timer_inc == TMR_W'(TIMEOUT));
  assign exp_bad   = (exp_num == '0) || (int'(exp_num) > NUM_EXP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_EXP; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
      pend_q      <= '0;
      exp_q       <= '0;
      match_cnt_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= 2'd0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we && int'(cfg_idx) < NUM_EXP) begin
            tab_addr_q[cfg_idx] <= cfg_addr;
            tab_data_q[cfg_idx] <= cfg_data;
          end
          if (start) begin
            if (exp_bad) begin
              state_q     <= S_FAIL;
              done_q      <= 1'b1;
              fail_q      <= 1'b1;
              fail_code_q <= 2'd3;
            end else begin
              state_q     <= S_RUN;
              busy_q      <= 1'b1;
              exp_q       <= exp_num;
              match_cnt_q <= '0;
              timer_q     <= '0;
              pend_q      <= pend_init;
            end
          end
        end
        S_RUN: begin
          timer_q <= timer_inc;
          if (memwrite && hit) begin
            match_cnt_q     <= cnt_inc;
            pend_q[hit_idx] <= 1'b0;
          end
          // completing match beats timeout; mismatch beats timeout
          if (fin) begin
            state_q <= S_PASS;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (mism) begin
            state_q     <= S_FAIL;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_code_q <= 2'd1;
            fail_addr_q <= dataadr;
            fail_data_q <= writedata;
          end else if (tmo) begin
            state_q     <= S_FAIL;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_code_q <= 2'd2;
          end
        end
        default: begin
          if (clr) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            match_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives an ordered and an unordered checker in lockstep and compares both against
// a table/queue-level reference model of the store-checking rules.
module tb_mem_write_checker;
  localparam int W  = 32;
  localparam int NE = 4;
  localparam int TO = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_idx = '0;
  logic [W-1:0] cfg_addr = '0, cfg_data = '0;
  logic         ign_en = 1'b0;
  logic [W-1:0] ign_addr = '0;
  logic [2:0]   exp_num = '0;
  logic         start = 1'b0, clr = 1'b0, memwrite = 1'b0;
  logic [W-1:0] dataadr = '0, writedata = '0;

  logic         busy_w [2], done_w [2], pass_w [2], fail_w [2];
  logic [1:0]   code_w [2];
  logic [2:0]   cnt_w  [2];
  logic [W-1:0] fa_w   [2], fd_w [2];

  int checks = 0;
  int errors = 0;
  string cur_tag = "reset";

  // reference model state, index 0 = ordered, 1 = unordered
  int           m_st [2], m_code [2], m_cnt [2], m_exp [2], m_tmr [2];
  logic [W-1:0] m_fa [2], m_fd [2];
  logic [W-1:0] m_ta [2][NE], m_td [2][NE];
  bit           m_pend [2][NE];

  always #5 clk = ~clk;

  mem_write_checker #(.WIDTH(W), .NUM_EXP(NE), .TIMEOUT(TO), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ign_en(ign_en), .ign_addr(ign_addr), .exp_num(exp_num),
    .start(start), .clr(clr), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
    .fail_code(code_w[0]), .match_cnt(cnt_w[0]), .fail_addr(fa_w[0]), .fail_data(fd_w[0]));

  mem_write_checker #(.WIDTH(W), .NUM_EXP(NE), .TIMEOUT(TO), .ORDERED(0)) u_unord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ign_en(ign_en), .ign_addr(ign_addr), .exp_num(exp_num),
    .start(start), .clr(clr), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
    .fail_code(code_w[1]), .match_cnt(cnt_w[1]), .fail_addr(fa_w[1]), .fail_data(fd_w[1]));

  function automatic void model_reset(int m);
    m_st[m] = M_IDLE; m_code[m] = 0; m_cnt[m] = 0; m_exp[m] = 0; m_tmr[m] = 0;
    m_fa[m] = '0; m_fd[m] = '0;
    for (int k = 0; k < NE; k++) begin
      m_ta[m][k] = '0; m_td[m][k] = '0; m_pend[m][k] = 1'b0;
    end
  endfunction

  // One clock edge worth of behaviour, from the current input values.
  function automatic void model_step(int m);
    bit matched, addr_seen;
    int which;
    if (!reset) begin
      model_reset(m);
      return;
    end
    case (m_st[m])
      M_IDLE: begin
        if (cfg_we && cfg_idx < NE) begin
          m_ta[m][cfg_idx] = cfg_addr;
          m_td[m][cfg_idx] = cfg_data;
        end
        if (start) begin
          if (exp_num == 0 || exp_num > NE) begin
            m_st[m] = M_FAIL; m_code[m] = 3;
          end else begin
            m_st[m] = M_RUN; m_exp[m] = int'(exp_num); m_cnt[m] = 0; m_tmr[m] = 0;
            for (int k = 0; k < NE; k++) m_pend[m][k] = (k < m_exp[m]);
          end
        end
      end
      M_RUN: begin
        m_tmr[m]++;
        if (memwrite) begin
          matched = 0; addr_seen = 0; which = 0;
          if (m == 0) begin
            which     = m_cnt[m];
            addr_seen = (m_ta[m][which] == dataadr);
            matched   = addr_seen && (m_td[m][which] == writedata);
          end else begin
            for (int k = 0; k < m_exp[m]; k++) begin
              if (m_pend[m][k] && m_ta[m][k] == dataadr) begin
                addr_seen = 1;
                if (!matched && m_td[m][k] == writedata) begin
                  matched = 1; which = k;
                end
              end
            end
          end
          if (matched) begin
            m_pend[m][which] = 1'b0;
            m_cnt[m]++;
            if (m_cnt[m] == m_exp[m]) begin
              m_st[m] = M_PASS;
              return;
            end
          end else if (!(ign_en && dataadr == ign_addr && !addr_seen)) begin
            m_st[m] = M_FAIL; m_code[m] = 1; m_fa[m] = dataadr; m_fd[m] = writedata;
            return;
          end
        end
        if (m_tmr[m] == TO) begin
          m_st[m] = M_FAIL; m_code[m] = 2;
        end
      end
      default: begin
        if (clr) begin
          m_st[m] = M_IDLE; m_code[m] = 0; m_cnt[m] = 0; m_fa[m] = '0; m_fd[m] = '0;
        end
      end
    endcase
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    string n;
    for (int m = 0; m < 2; m++) begin
      n = $sformatf("%s/%s", cur_tag, (m == 0) ? "ord" : "unord");
      chk({n, "/busy"},  W'(busy_w[m]), W'(m_st[m] == M_RUN));
      chk({n, "/done"},  W'(done_w[m]), W'(m_st[m] == M_PASS || m_st[m] == M_FAIL));
      chk({n, "/pass"},  W'(pass_w[m]), W'(m_st[m] == M_PASS));
      chk({n, "/fail"},  W'(fail_w[m]), W'(m_st[m] == M_FAIL));
      chk({n, "/code"},  W'(code_w[m]), W'(m_code[m]));
      chk({n, "/cnt"},   W'(cnt_w[m]),  W'(m_cnt[m]));
      chk({n, "/faddr"}, fa_w[m], m_fa[m]);
      chk({n, "/fdata"}, fd_w[m], m_fd[m]);
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cfg(int idx, int a, int d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = W'(a); cfg_data = W'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic store(int a, int d);
    memwrite = 1'b1; dataadr = W'(a); writedata = W'(d);
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_start(int n);
    exp_num = 3'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k;
    model_reset(0);
    model_reset(1);
    #12;
    check_all();
    #10 reset = 1'b1;
    tick();

    cur_tag = "table_cleared";
    do_start(1);
    store(0, 0);
    chk("table_cleared/pass", W'(pass_w[0]), W'(1));
    do_clr();

    cur_tag = "single";
    cfg(0, 84, 7);
    ign_en = 1'b1; ign_addr = 80;
    do_start(1);
    store(80, 5);
    store(84, 7);
    chk("single/pass", W'(pass_w[0]), W'(1));
    chk("single/cnt", W'(cnt_w[0]), W'(1));
    tick();
    do_clr();

    cur_tag = "mismatch";
    do_start(1);
    store(84, 6);
    chk("mismatch/code", W'(code_w[0]), W'(1));
    chk("mismatch/faddr", fa_w[0], W'(84));
    chk("mismatch/fdata", fd_w[0], W'(6));
    store(84, 7);
    do_clr();

    cur_tag = "order";
    cfg(1, 88, 9);
    do_start(2);
    store(88, 9);
    chk("order/ord_code", W'(code_w[0]), W'(1));
    store(84, 7);
    chk("order/unord_pass", W'(pass_w[1]), W'(1));
    chk("order/unord_cnt", W'(cnt_w[1]), W'(2));
    tick();
    do_clr();

    cur_tag = "timeout";
    do_start(1);
    for (int i = 0; i < TO; i++) begin
      tick();
      if (i == TO - 2) chk("timeout/still_busy", W'(busy_w[0]), W'(1));
    end
    chk("timeout/code", W'(code_w[0]), W'(2));
    do_clr();

    cur_tag = "timeout_pass";
    do_start(1);
    for (int i = 0; i < TO - 1; i++) tick();
    store(84, 7);
    chk("timeout_pass/pass", W'(pass_w[0]), W'(1));
    do_clr();

    cur_tag = "badcfg";
    do_start(0);
    chk("badcfg0/code", W'(code_w[0]), W'(3));
    do_clr();
    do_start(NE + 1);
    chk("badcfg5/code", W'(code_w[1]), W'(3));
    do_clr();

    cur_tag = "cfg_in_run";
    do_start(1);
    cfg(0, 100, 1);
    store(84, 7);
    chk("cfg_in_run/pass", W'(pass_w[0]), W'(1));
    do_clr();

    cur_tag = "rand";
    for (int it = 0; it < 30; it++) begin
      ign_en = 1'($urandom_range(0, 1));
      ign_addr = W'(80 + 4 * $urandom_range(0, 5));
      for (int e = 0; e < NE; e++)
        cfg(e, 80 + 4 * int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      do_start(int'($urandom_range(1, NE)));
      for (int c = 0; c < TO + 2 && (m_st[0] == M_RUN || m_st[1] == M_RUN); c++) begin
        r = int'($urandom_range(0, 9));
        k = int'($urandom_range(0, NE - 1));
        memwrite = (r != 8);
        if (r < 6) begin
          dataadr = m_ta[0][k]; writedata = m_td[0][k];
        end else if (r == 6) begin
          dataadr = ign_addr; writedata = W'($urandom_range(0, 3));
        end else if (r == 7) begin
          dataadr = m_ta[0][k]; writedata = m_td[0][k] + 1;
        end else begin
          dataadr = W'(80 + 4 * $urandom_range(0, 5)); writedata = W'($urandom_range(0, 3));
        end
        cfg_we = ($urandom_range(0, 7) == 0);
        cfg_idx = 2'($urandom_range(0, NE - 1));
        cfg_addr = W'($urandom);
        cfg_data = W'($urandom);
        tick();
      end
      memwrite = 1'b0;
      cfg_we = 1'b0;
      do_clr();
    end

    cur_tag = "async_reset";
    do_start(1);
    tick();
    chk("async_reset/busy_before", W'(busy_w[0]), W'(1));
    #3 reset = 1'b0;
    #1;
    chk("async_reset/ord_busy", W'(busy_w[0]), W'(0));
    chk("async_reset/unord_busy", W'(busy_w[1]), W'(0));
    model_reset(0);
    model_reset(1);
    check_all();
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
